mem_boot_loader: RTL and testbench

- Synthesizable boot/initialisation controller for the MIPS CPU.
- Runs after Reset and before the core executes:
  - fills the register file and data memory with a deterministic index pattern, including one optional patched data word;
  - streams a program into instruction memory over a valid/ready handshake;
  - then releases the core's reset.
- Sits between the top-level Clk/Reset and the CPU's RegFile, RAM and ROM write ports. It replaces bench-only initial blocks with hardware, so the same boot sequence works on FPGA.

---
 rtl/mem_boot_loader_if.sv | 39 +++
 rtl/mem_boot_loader.sv | 144 ++++++++++++++
 tb/tb_mem_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_boot_loader_if.sv
// Boot-loader bus: program-load handshake in, RF/DM/IM write ports and core control out.
// Pure wiring, no latency; load_ready is the only backpressure signal toward the program source.
// master = loader side, slave = the memories / program source side.
interface mem_boot_loader_if #(
    parameter int WIDTH = 32,
    parameter int RF_AW = 5,
    parameter int DM_AW = 5,
    parameter int IM_AW = 6
);
    logic             reload;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             load_ready;
    logic             rf_we;
    logic [RF_AW-1:0] rf_addr;
    logic [WIDTH-1:0] rf_wdata;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic             im_we;
    logic [IM_AW-1:0] im_addr;
    logic [WIDTH-1:0] im_wdata;
    logic             cpu_reset;
    logic             done;
    logic             overflow;

    modport master (
        input  reload, load_valid, load_data, load_last,
        output load_ready, rf_we, rf_addr, rf_wdata, dm_we, dm_addr, dm_wdata,
               im_we, im_addr, im_wdata, cpu_reset, done, overflow
    );

    modport slave (
        output reload, load_valid, load_data, load_last,
        input  load_ready, rf_we, rf_addr, rf_wdata, dm_we, dm_addr, dm_wdata,
               im_we, im_addr, im_wdata, cpu_reset, done, overflow
    );
endinterface

// File: rtl/mem_boot_loader.sv
// Boot controller: index-pattern fill of RF/DM, program stream into IM, then core reset release.
// Latency: INIT lasts max(RF_DEPTH,DM_DEPTH) cycles; IM write is in the cycle the word is accepted.
// Backpressure: load_ready is high only in LOAD and depends on state alone, never on load_valid.
module mem_boot_loader #(
    parameter int          WIDTH       = 32,
    parameter int          RF_DEPTH    = 32,
    parameter int          DM_DEPTH    = 32,
    parameter int          IM_DEPTH    = 64,
    parameter int          STRIDE      = 4,
    parameter bit          PATCH_EN    = 1'b1,
    parameter int          PATCH_ADDR  = 2,
    parameter logic [31:0] PATCH_DATA  = 32'h123489ab,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_boot_loader_if.master bus
);
    localparam int MAX_DEPTH = (RF_DEPTH > DM_DEPTH) ? RF_DEPTH : DM_DEPTH;
    localparam int IW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int RF_AW     = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int DM_AW     = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
    localparam int KW        = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam int HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_INIT, S_LOAD, S_RELEASE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [KW-1:0]   k_q, k_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            ovf_q, ovf_d;
    logic [WIDTH-1:0] pattern;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            i_q     <= '0;
            k_q     <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pattern = WIDTH'(i_q) * WIDTH'(STRIDE);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;

        bus.load_ready = 1'b0;
        bus.rf_we      = 1'b0;
        bus.rf_addr    = '0;
        bus.rf_wdata   = '0;
        bus.dm_we      = 1'b0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.im_we      = 1'b0;
        bus.im_addr    = '0;
        bus.im_wdata   = '0;
        bus.cpu_reset  = 1'b1;
        bus.done       = 1'b0;
        bus.overflow   = ovf_q;

        case (state_q)
            S_INIT: begin
                bus.rf_we    = int'(i_q) < RF_DEPTH;
                bus.rf_addr  = RF_AW'(i_q);
                bus.rf_wdata = pattern;
                bus.dm_we    = int'(i_q) < DM_DEPTH;
                bus.dm_addr  = DM_AW'(i_q);
                bus.dm_wdata = (PATCH_EN && int'(i_q) == PATCH_ADDR) ? WIDTH'(PATCH_DATA) : pattern;
                if (i_q == IW'(MAX_DEPTH - 1)) begin
                    state_d = S_LOAD;
                    i_d     = '0;
                    k_d     = '0;
                    ovf_d   = 1'b0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_LOAD: begin
                bus.load_ready = 1'b1;
                bus.im_addr    = k_q;
                if (bus.load_valid) begin
                    bus.im_we    = 1'b1;
                    bus.im_wdata = bus.load_data;
                    // k stops at the last slot: a full IM without load_last is an overflow, not a wrap
                    if (bus.load_last || k_q == KW'(IM_DEPTH - 1)) begin
                        ovf_d   = !bus.load_last;
                        hold_d  = '0;
                        state_d = (HOLD_CYCLES == 0) ? S_RUN : S_RELEASE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_RELEASE: begin
                if (hold_q == HW'(HOLD_LAST)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                bus.cpu_reset = 1'b0;
                bus.done      = 1'b1;
                if (bus.reload) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Reset is synchronous but must silence the write ports in the very cycle it is applied
        if (Reset) begin
            bus.load_ready = 1'b0;
            bus.rf_we      = 1'b0;
            bus.rf_addr    = '0;
            bus.rf_wdata   = '0;
            bus.dm_we      = 1'b0;
            bus.dm_addr    = '0;
            bus.dm_wdata   = '0;
            bus.im_we      = 1'b0;
            bus.im_addr    = '0;
            bus.im_wdata   = '0;
            bus.cpu_reset  = 1'b1;
            bus.done       = 1'b0;
            bus.overflow   = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// Two loaders (default and a small DM/IM, zero-hold variant) share one randomized stimulus stream
// and are compared every cycle against a phase-level reference model.
module tb_mem_boot_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic        load_valid;
    logic        load_last;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_boot_loader_if #(.WIDTH(32), .RF_AW(5), .DM_AW(5), .IM_AW(6)) ifa ();
    mem_boot_loader_if #(.WIDTH(32), .RF_AW(5), .DM_AW(3), .IM_AW(2)) ifb ();

    assign ifa.reload     = reload;
    assign ifa.load_valid = load_valid;
    assign ifa.load_data  = load_data;
    assign ifa.load_last  = load_last;
    assign ifb.reload     = reload;
    assign ifb.load_valid = load_valid;
    assign ifb.load_data  = load_data;
    assign ifb.load_last  = load_last;

    mem_boot_loader dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifa.master)
    );

    mem_boot_loader #(
        .DM_DEPTH    (8),
        .IM_DEPTH    (4),
        .HOLD_CYCLES (0),
        .PATCH_EN    (1'b0)
    ) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifb.master)
    );

    typedef struct packed {
        logic        rf_we;
        logic [31:0] rf_addr;
        logic [31:0] rf_wdata;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        im_we;
        logic [31:0] im_addr;
        logic [31:0] im_wdata;
        logic        ready;
        logic        cpu_reset;
        logic        done;
        logic        ovf;
    } obs_t;

    obs_t obs [2];

    always_comb begin
        obs[0].rf_we     = ifa.rf_we;
        obs[0].rf_addr   = 32'(ifa.rf_addr);
        obs[0].rf_wdata  = ifa.rf_wdata;
        obs[0].dm_we     = ifa.dm_we;
        obs[0].dm_addr   = 32'(ifa.dm_addr);
        obs[0].dm_wdata  = ifa.dm_wdata;
        obs[0].im_we     = ifa.im_we;
        obs[0].im_addr   = 32'(ifa.im_addr);
        obs[0].im_wdata  = ifa.im_wdata;
        obs[0].ready     = ifa.load_ready;
        obs[0].cpu_reset = ifa.cpu_reset;
        obs[0].done      = ifa.done;
        obs[0].ovf       = ifa.overflow;
        obs[1].rf_we     = ifb.rf_we;
        obs[1].rf_addr   = 32'(ifb.rf_addr);
        obs[1].rf_wdata  = ifb.rf_wdata;
        obs[1].dm_we     = ifb.dm_we;
        obs[1].dm_addr   = 32'(ifb.dm_addr);
        obs[1].dm_wdata  = ifb.dm_wdata;
        obs[1].im_we     = ifb.im_we;
        obs[1].im_addr   = 32'(ifb.im_addr);
        obs[1].im_wdata  = ifb.im_wdata;
        obs[1].ready     = ifb.load_ready;
        obs[1].cpu_reset = ifb.cpu_reset;
        obs[1].done      = ifb.done;
        obs[1].ovf       = ifb.overflow;
    end

    // Per-instance configuration as seen by the reference model
    function automatic int cfg_rf(int d);    return 32;                  endfunction
    function automatic int cfg_dm(int d);    return (d == 0) ? 32 : 8;   endfunction
    function automatic int cfg_im(int d);    return (d == 0) ? 64 : 4;   endfunction
    function automatic int cfg_hold(int d);  return (d == 0) ? 2 : 0;    endfunction
    function automatic bit cfg_patch(int d); return (d == 0);            endfunction

    // Reference phases: 0 fill, 1 program load, 2 reset hold, 3 running
    int ph    [2];
    int idx   [2];
    int kk    [2];
    int hleft [2];
    bit ovf   [2];
    bit acc   [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_step(int d);
        obs_t        o;
        string       p;
        int          mx;
        bit          e_rf, e_dm, e_im;
        logic [31:0] e_dmd;
        o  = obs[d];
        p  = (d == 0) ? "a" : "b";
        mx = (cfg_rf(d) > cfg_dm(d)) ? cfg_rf(d) : cfg_dm(d);
        acc[d] = 1'b0;
        if (rst) begin
            check({p, ".rst.rf_we"}, 32'(o.rf_we), 0);
            check({p, ".rst.dm_we"}, 32'(o.dm_we), 0);
            check({p, ".rst.im_we"}, 32'(o.im_we), 0);
            check({p, ".rst.ready"}, 32'(o.ready), 0);
            check({p, ".rst.cpu_reset"}, 32'(o.cpu_reset), 1);
            check({p, ".rst.done"}, 32'(o.done), 0);
            check({p, ".rst.overflow"}, 32'(o.ovf), 0);
            ph[d] = 0; idx[d] = 0; kk[d] = 0; ovf[d] = 1'b0;
        end else begin
            check({p, ".ready"}, 32'(o.ready), 32'(ph[d] == 1));
            check({p, ".cpu_reset"}, 32'(o.cpu_reset), 32'(ph[d] != 3));
            check({p, ".done"}, 32'(o.done), 32'(ph[d] == 3));
            check({p, ".overflow"}, 32'(o.ovf), 32'(ovf[d]));
            e_rf = (ph[d] == 0) && (idx[d] < cfg_rf(d));
            e_dm = (ph[d] == 0) && (idx[d] < cfg_dm(d));
            e_im = (ph[d] == 1) && load_valid;
            check({p, ".rf_we"}, 32'(o.rf_we), 32'(e_rf));
            check({p, ".dm_we"}, 32'(o.dm_we), 32'(e_dm));
            check({p, ".im_we"}, 32'(o.im_we), 32'(e_im));
            if (e_rf) begin
                check({p, ".rf_addr"}, o.rf_addr, 32'(idx[d]));
                check({p, ".rf_wdata"}, o.rf_wdata, 32'(idx[d] * 4));
            end
            if (e_dm) begin
                e_dmd = (cfg_patch(d) && idx[d] == 2) ? 32'h123489ab : 32'(idx[d] * 4);
                check({p, ".dm_addr"}, o.dm_addr, 32'(idx[d]));
                check({p, ".dm_wdata"}, o.dm_wdata, e_dmd);
            end
            if (e_im) begin
                check({p, ".im_addr"}, o.im_addr, 32'(kk[d]));
                check({p, ".im_wdata"}, o.im_wdata, load_data);
            end
            case (ph[d])
                0: begin
                    if (idx[d] == mx - 1) begin
                        ph[d] = 1; idx[d] = 0; kk[d] = 0; ovf[d] = 1'b0;
                    end else begin
                        idx[d]++;
                    end
                end
                1: begin
                    if (load_valid) begin
                        acc[d] = 1'b1;
                        if (load_last || kk[d] == cfg_im(d) - 1) begin
                            ovf[d]   = !load_last;
                            hleft[d] = cfg_hold(d);
                            ph[d]    = (cfg_hold(d) == 0) ? 3 : 2;
                        end else begin
                            kk[d]++;
                        end
                    end
                end
                2: begin
                    hleft[d]--;
                    if (hleft[d] == 0) ph[d] = 3;
                end
                default: begin
                    if (reload) begin
                        ph[d] = 1; kk[d] = 0; ovf[d] = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int c = 0; c < n; c++) begin
            load_valid = 1'($urandom);
            load_last  = 1'($urandom);
            load_data  = $urandom;
            reload     = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Offers words to both loaders; the stream advances on acceptance by instance a
    task automatic stream(int nwords, int last_at, bit toggle);
        int n = 0;
        int c = 0;
        while (n < nwords && ph[0] == 1 && c < 2000) begin
            load_valid = toggle ? ((c % 2) == 1) : ($urandom_range(0, 3) != 0);
            load_data  = 32'h20080000 + 32'(n);
            load_last  = (n == last_at);
            tick();
            if (acc[0]) n++;
            c++;
        end
        if (c >= 2000) check("stream_timeout", 32'(c), 0);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fill_phase();
        for (int c = 0; c < 32; c++) begin
            load_valid = 1'($urandom);
            load_last  = 1'($urandom);
            load_data  = $urandom;
            reload     = 1'($urandom);
            tick();
        end
        reload     = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        reload     = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        fill_phase();
        stream(28, 27, 1'b1);
        idle(6);

        pulse_reload();
        stream(3, 2, 1'b0);
        idle(4);

        pulse_reload();
        stream(80, -1, 1'b0);
        idle(5);

        pulse_reload();
        stream(11, -1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill_phase();
        stream(5, 4, 1'b0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
